apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter that multiplexes NREQ request channels onto one APB
// master command port. A winner is chosen in IDLE, its command is registered
// and held while the bus transfer runs (BUSY), and a one-cycle DONE state
// reports completion back to the winner before the pointer advances.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  watchdog limit in PCLK cycles (2..255), used only when the
//            APB_ARB_TIMEOUT_EN macro is defined
//
// Optional feature
//   `define APB_ARB_TIMEOUT_EN  adds an 8-bit BUSY-cycle watchdog; on expiry
//                               the transfer is finished with err=1, rdata=0.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req/req_write         per-requester request level and direction
//   req_addr/req_wdata    per-requester address/data, 32 bits per requester
//   gnt, done             one-hot grant and one-cycle completion pulse
//   rdata, err            result of the last completed transfer
//   SWRITE/SADDR/SWDATA   command presented to the APB master
//   transfer              high while a transfer is in progress
//   PSEL/PENABLE/PREADY/PSLVERR/PRDATA  monitored APB bus signals
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [31:0]        rdata,
    output logic               err,
    output logic               SWRITE,
    output logic [31:0]        SADDR,
    output logic [31:0]        SWDATA,
    output logic               transfer,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PREADY,
    input  logic               PSLVERR,
    input  logic [31:0]        PRDATA
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("apb_req_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("apb_req_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   gidx_reg;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    logic            complete;
    logic            timeout;
    logic [NREQ-1:0] gnt_reg;
    logic            swrite_reg;
    logic [31:0]     saddr_reg;
    logic [31:0]     swdata_reg;
    logic [31:0]     rdata_reg;
    logic            err_reg;

    logic [31:0]     addr_arr  [NREQ];
    logic [31:0]     wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*32 +: 32];
            assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
        end
    endgenerate

    assign complete = PSEL & PENABLE & PREADY;

    // Round-robin pick: scan from ptr upward with wrap. Iterating the offset
    // from high to low lets the smallest offset (closest to ptr) win.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [PW:0] cand;
            cand = {1'b0, ptr_reg} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (req[cand[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Held at zero outside BUSY so it always starts from zero on BUSY entry;
    // in BUSY cycle k it holds k-1, so expiry ends BUSY after TIMEOUT cycles.
    logic [7:0] cnt_reg;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_reg <= '0;
        end else if (state_reg != BUSY) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign timeout = (cnt_reg == 8'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_valid) state_next = BUSY;
            BUSY:    if (complete || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr_reg    <= '0;
            gidx_reg   <= '0;
            gnt_reg    <= '0;
            swrite_reg <= 1'b0;
            saddr_reg  <= '0;
            swdata_reg <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        gidx_reg   <= win_idx;
                        gnt_reg    <= NREQ'(1) << win_idx;
                        swrite_reg <= req_write[win_idx];
                        saddr_reg  <= addr_arr[win_idx];
                        swdata_reg <= wdata_arr[win_idx];
                    end
                end
                BUSY: begin
                    // A real completion takes priority over a coincident
                    // watchdog expiry.
                    if (complete) begin
                        rdata_reg <= swrite_reg ? 32'd0 : PRDATA;
                        err_reg   <= PSLVERR;
                    end else if (timeout) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b1;
                    end
                end
                DONE: begin
                    gnt_reg <= '0;
                    ptr_reg <= (gidx_reg == PW'(NREQ - 1)) ? '0 : gidx_reg + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign done     = (state_reg == DONE) ? gnt_reg : '0;
    assign transfer = (state_reg == BUSY);
    assign SWRITE   = swrite_reg;
    assign SADDR    = saddr_reg;
    assign SWDATA   = swdata_reg;
    assign rdata    = rdata_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Self-checking bench for apb_req_arbiter (NREQ=4, TIMEOUT=16). A directed
// table of transfers with hand-computed results, hand-written sequences for
// reset mid-transfer, fairness and (with APB_ARB_TIMEOUT_EN) the watchdog,
// then randomized transfers checked against a round-robin reference model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int N = 4;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic [N-1:0]   req;
    logic [N-1:0]   req_write;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [31:0]    rdata;
    logic           err;
    logic           SWRITE;
    logic [31:0]    SADDR;
    logic [31:0]    SWDATA;
    logic           transfer;
    logic           PSEL;
    logic           PENABLE;
    logic           PREADY;
    logic           PSLVERR;
    logic [31:0]    PRDATA;

    int vectors     = 0;
    int miscompares = 0;
    int mptr        = 0;   // reference model round-robin pointer

    always #5 PCLK = ~PCLK;

    apb_req_arbiter #(.NREQ(N), .TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .SWRITE    (SWRITE),
        .SADDR     (SADDR),
        .SWDATA    (SWDATA),
        .transfer  (transfer),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PRDATA    (PRDATA)
    );

    typedef struct {
        logic [3:0]  r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          waitc;
        logic        slverr;
        logic [31:0] prd;
        logic [3:0]  eg;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference round-robin choice: first set bit scanning from p with wrap.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic bus_idle();
        PSEL = 1'b0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    endtask

    // One full transfer starting from IDLE on a falling edge. All requester
    // fields are randomized, then the expected winner's fields are set to w/a/d.
    task automatic run_xfer(input logic [3:0] r, input bit hold, input int waitc,
                            input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic slverr, input logic [31:0] prd,
                            input logic [3:0] eg, input logic [31:0] erd, input logic eerr);
        int gix;
        gix = 0;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) gix = i;
            req_write[i]          = 1'($urandom);
            req_addr[i*32 +: 32]  = $urandom;
            req_wdata[i*32 +: 32] = $urandom;
        end
        req_write[gix]          = w;
        req_addr[gix*32 +: 32]  = a;
        req_wdata[gix*32 +: 32] = d;
        req = r;
        bus_idle();
        @(negedge PCLK);
        chk("gnt_busy", 32'(gnt), 32'(eg));
        chk("transfer_busy", 32'(transfer), 32'd1);
        chk("swrite", 32'(SWRITE), 32'(w));
        chk("saddr", SADDR, a);
        chk("swdata", SWDATA, d);
        chk("done_busy", 32'(done), 32'd0);
        // Granted requester drops its request; other channels churn freely.
        if (!hold) req = 4'($urandom) & ~eg;
        req_write = 4'($urandom);
        req_addr  = {$urandom, $urandom, $urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        // Setup phase with PREADY already high: not a completion without PENABLE.
        PSEL = 1'b1; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
        @(negedge PCLK);
        chk("transfer_setup", 32'(transfer), 32'd1);
        for (int n = 0; n <= waitc; n++) begin
            PENABLE = 1'b1;
            PREADY  = (n == waitc);
            PSLVERR = (n == waitc) ? slverr : 1'b1;
            PRDATA  = (n == waitc) ? prd : $urandom;
            @(negedge PCLK);
            if (n < waitc) chk("transfer_wait", 32'(transfer), 32'd1);
        end
        chk("done_pulse", 32'(done), 32'(eg));
        chk("gnt_done", 32'(gnt), 32'(eg));
        chk("transfer_done", 32'(transfer), 32'd0);
        chk("rdata", rdata, erd);
        chk("err", 32'(err), 32'(eerr));
        chk("saddr_done", SADDR, a);
        // Completion signalled in DONE must be ignored.
        PSEL = 1'b1; PENABLE = 1'b1; PREADY = 1'b1; PRDATA = ~prd; PSLVERR = ~slverr;
        @(negedge PCLK);
        chk("done_cleared", 32'(done), 32'd0);
        chk("gnt_idle", 32'(gnt), 32'd0);
        chk("rdata_hold", rdata, erd);
        chk("err_hold", 32'(err), 32'(eerr));
        if (!hold) begin
            // Completion signalled in IDLE with no request must be ignored.
            req = '0;
            @(negedge PCLK);
            chk("idle_stays", 32'({transfer, gnt}), 32'd0);
            chk("rdata_idle_hold", rdata, erd);
        end
        bus_idle();
        mptr = (gix + 1) % N;
        $display("xfer req=%b gnt=%b write=%b addr=%h wdata=%h rdata=%h err=%b",
                 r, eg, w, a, d, rdata, err);
    endtask

    initial begin
        logic [3:0]  r;
        logic        w;
        logic [31:0] a, d, prd;
        logic        slv;
        int          g;

        tbl[0] = '{4'b0001, 1'b1, 32'h10, 32'hA5A5A5A5, 0, 1'b0, 32'h11111111, 4'b0001, 32'h0,        1'b0};
        tbl[1] = '{4'b0100, 1'b0, 32'h20, 32'h0,        1, 1'b0, 32'hDEADBEEF, 4'b0100, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{4'b0101, 1'b0, 32'h30, 32'h0,        2, 1'b1, 32'h0BADF00D, 4'b0001, 32'h0BADF00D, 1'b1};
        tbl[3] = '{4'b1001, 1'b1, 32'h40, 32'h12345678, 0, 1'b0, 32'h22222222, 4'b1000, 32'h0,        1'b0};
        tbl[4] = '{4'b0110, 1'b0, 32'h50, 32'h0,        3, 1'b0, 32'hCAFEF00D, 4'b0010, 32'hCAFEF00D, 1'b0};
        tbl[5] = '{4'b0011, 1'b0, 32'h60, 32'h0,        0, 1'b0, 32'h55AA55AA, 4'b0001, 32'h55AA55AA, 1'b0};

        PRESET = 1'b1;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        bus_idle();
        @(posedge PCLK);
        #1;
        chk("rst_outputs", 32'({gnt, done, transfer, SWRITE, err}), 32'd0);
        chk("rst_saddr", SADDR, 32'd0);
        chk("rst_swdata", SWDATA, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        mptr = 0;

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].r, 1'b0, tbl[i].waitc, tbl[i].w, tbl[i].a, tbl[i].d,
                     tbl[i].slverr, tbl[i].prd, tbl[i].eg, tbl[i].erd, tbl[i].eerr);
        end

        // Reset pulsed mid-BUSY (pointer is 1 here, rdata nonzero).
        req = 4'b0100;
        @(negedge PCLK);
        chk("pre_rst_transfer", 32'(transfer), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({gnt, done, transfer, SWRITE, err}), 32'd0);
        chk("rst_mid_saddr", SADDR, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        @(negedge PCLK);
        chk("rst_no_done", 32'({done, transfer}), 32'd0);
        PRESET = 1'b0;
        mptr = 0;

        // Fairness with all requests held: 0,1,2,3,0. First grant also proves
        // the pointer returned to 0 and arbitration on the first edge.
        for (int i = 0; i < 5; i++) begin
            prd = $urandom;
            run_xfer(4'b1111, 1'b1, i % 3, 1'b0, 32'h100 + 32'(i), 32'h0, 1'b0, prd,
                     4'(1 << (i % 4)), prd, 1'b0);
        end
        req = '0;
        @(negedge PCLK);

        // Randomized transfers against the reference model.
        for (int it = 0; it < 40; it++) begin
            r = 4'($urandom);
            if (r == 4'b0000) begin
                req = '0;
                bus_idle();
                @(negedge PCLK);
                chk("no_req_idle", 32'({gnt, transfer}), 32'd0);
            end else begin
                g   = rr_pick(r, mptr);
                w   = 1'($urandom);
                a   = $urandom;
                d   = $urandom;
                prd = $urandom;
                slv = ($urandom_range(0, 3) == 0);
                run_xfer(r, 1'($urandom), $urandom_range(0, 4), w, a, d, slv, prd,
                         4'(1 << g), w ? 32'h0 : prd, slv);
            end
        end
        req = '0;
        @(negedge PCLK);

`ifdef APB_ARB_TIMEOUT_EN
        begin
            int cyc;
            g = rr_pick(4'b0001, mptr);
            req = 4'b0001;
            PSEL = 1'b1; PENABLE = 1'b1; PREADY = 1'b0;
            cyc = 0;
            do begin
                @(negedge PCLK);
                cyc++;
            end while (done == '0 && cyc < 40);
            chk("timeout_cycles", 32'(cyc), 32'd17);
            chk("timeout_done", 32'(done), 32'b0001);
            chk("timeout_err", 32'(err), 32'd1);
            chk("timeout_rdata", rdata, 32'd0);
            req = '0;
            bus_idle();
            @(negedge PCLK);
            mptr = (g + 1) % N;
            g = rr_pick(4'b0011, mptr);
            prd = $urandom;
            run_xfer(4'b0011, 1'b0, 1, 1'b0, 32'h70, 32'h0, 1'b0, prd, 4'(1 << g), prd, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
